// File: rtl/z80_blkctl.sv
// ---------------------------------------------------------------------------
// z80_blkctl
//
// Multi-cycle sequencer for the Z80 block-transfer and block-compare group
// (LDI, LDD, LDIR, LDDR, CPI, CPD, CPIR, CPDR). While one of these ED-prefixed
// instructions runs, it drives the memory bus. It returns updated HL/DE/BC and
// F, including the undocumented X (bit 3) and Y (bit 5) flags.
//
// Build option:
//   Z80_BLKCTL_REPEAT_EN  defined   -> repeating ops loop internally until they
//                                      finish, or until brk is seen in CALC.
//                         undefined -> every op runs exactly one iteration and
//                                      reports again=R, so the core re-executes
//                                      the instruction as a real Z80 does.
//
// Ports:
//   clock, reset       system clock; synchronous active-high reset
//   start              one-cycle request, honoured only in IDLE
//   op[2:0]            {rep, cp, dec}
//   a, f               accumulator and incoming flags (S Z Y H X P N C)
//   hl, de, bc         register snapshot, latched on start
//   brk                interrupt pending, sampled only in CALC
//   mem_req, mem_we    bus request / write strobe, held until mem_ack
//   address, o_data    bus address and write data
//   i_data, mem_ack    read data and transfer-complete from memory
//   hl_o, de_o, bc_o   working registers; they hold after DONE until next start
//   f_o                working flags
//   busy               high from the cycle after start through DONE
//   done               one-cycle completion pulse
//   again              valid with done; core rewinds PC by 2 and re-fetches
// ---------------------------------------------------------------------------
module z80_blkctl (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [7:0]  a,
  input  logic [7:0]  f,
  input  logic [15:0] hl,
  input  logic [15:0] de,
  input  logic [15:0] bc,
  input  logic        brk,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] address,
  output logic [7:0]  o_data,
  input  logic [7:0]  i_data,
  input  logic        mem_ack,
  output logic [15:0] hl_o,
  output logic [15:0] de_o,
  output logic [15:0] bc_o,
  output logic [7:0]  f_o,
  output logic        busy,
  output logic        done,
  output logic        again
);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR,
    CALC,
    DONE
  } state_t;

  state_t      state_reg;

  // Latched operation and operands.
  logic        rep_reg;
  logic        cp_reg;
  logic        dec_reg;
  logic [7:0]  a_reg;
  logic [7:0]  t_reg;

  // Single-iteration results, consumed in CALC.
  logic [15:0] hl_next;
  logic [15:0] de_next;
  logic [15:0] bc_next;
  logic [7:0]  f_next;
  logic [7:0]  diff;
  logic [7:0]  n_val;
  logic        half_borrow;
  logic        bc_nz;
  logic        rpt_next;

`ifndef Z80_BLKCTL_REPEAT_EN
  // brk only matters when the loop runs internally.
  logic unused_brk;
  assign unused_brk = brk;
`endif

  always_comb begin
    hl_next     = dec_reg ? (hl_o - 16'd1) : (hl_o + 16'd1);
    de_next     = de_o;
    bc_next     = bc_o - 16'd1;
    bc_nz       = (bc_next != 16'd0);
    diff        = a_reg - t_reg;
    half_borrow = (a_reg[3:0] < t_reg[3:0]);
    n_val       = 8'd0;
    f_next      = f_o;

    if (cp_reg) begin
      // Compare: the core's S Z H N come from A-T; C is preserved.
      // X/Y come from A-T-H, which is an undocumented Z80 quirk.
      n_val     = diff - {7'd0, half_borrow};
      f_next[7] = diff[7];
      f_next[6] = (diff == 8'd0);
      f_next[4] = half_borrow;
      f_next[1] = 1'b1;
    end else begin
      // Load: DE steps with HL; X/Y come from A+transferred byte.
      de_next   = dec_reg ? (de_o - 16'd1) : (de_o + 16'd1);
      n_val     = a_reg + t_reg;
      f_next[4] = 1'b0;
      f_next[1] = 1'b0;
    end

    f_next[5] = n_val[1];
    f_next[3] = n_val[3];
    f_next[2] = bc_nz;

    // A compare repeat also stops on a match.
    rpt_next = rep_reg & bc_nz & (~cp_reg | ~f_next[6]);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= IDLE;
      rep_reg   <= 1'b0;
      cp_reg    <= 1'b0;
      dec_reg   <= 1'b0;
      a_reg     <= 8'd0;
      t_reg     <= 8'd0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      address   <= 16'd0;
      o_data    <= 8'd0;
      hl_o      <= 16'd0;
      de_o      <= 16'd0;
      bc_o      <= 16'd0;
      f_o       <= 8'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      again     <= 1'b0;
    end else begin
      // done/again are single-cycle pulses; they are set only on the way into DONE.
      done  <= 1'b0;
      again <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (start) begin
            rep_reg   <= op[2];
            cp_reg    <= op[1];
            dec_reg   <= op[0];
            a_reg     <= a;
            hl_o      <= hl;
            de_o      <= de;
            bc_o      <= bc;
            f_o       <= f;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            address   <= hl;
            busy      <= 1'b1;
            state_reg <= RD;
          end
        end

        RD: begin
          if (mem_ack) begin
            t_reg <= i_data;
            if (cp_reg) begin
              mem_req   <= 1'b0;
              state_reg <= CALC;
            end else begin
              mem_we    <= 1'b1;
              address   <= de_o;
              o_data    <= i_data;
              state_reg <= WR;
            end
          end
        end

        WR: begin
          if (mem_ack) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            state_reg <= CALC;
          end
        end

        CALC: begin
          hl_o <= hl_next;
          de_o <= de_next;
          bc_o <= bc_next;
          f_o  <= f_next;
`ifdef Z80_BLKCTL_REPEAT_EN
          if (rpt_next && !brk) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            address   <= hl_next;
            state_reg <= RD;
          end else begin
            done      <= 1'b1;
            again     <= rpt_next & brk;
            state_reg <= DONE;
          end
`else
          done      <= 1'b1;
          again     <= rpt_next;
          state_reg <= DONE;
`endif
        end

        DONE: begin
          busy      <= 1'b0;
          state_reg <= IDLE;
        end

        default: begin
          mem_req   <= 1'b0;
          mem_we    <= 1'b0;
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_z80_blkctl.sv
// ---------------------------------------------------------------------------
// tb_z80_blkctl
//
// Directed bench for z80_blkctl. The bench pushes expected register/flag
// results and expected bus writes to scoreboard queues when it drives each
// operation. It pops and compares them when the DUT reports done or
// completes a write. A behavioural memory with programmable read/write wait
// states runs inside the per-cycle step task.
//
// Expectations follow Z80_BLKCTL_REPEAT_EN in the same way as the design.
// ---------------------------------------------------------------------------
module tb_z80_blkctl;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [7:0]  a;
  logic [7:0]  f;
  logic [15:0] hl;
  logic [15:0] de;
  logic [15:0] bc;
  logic        brk;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] address;
  logic [7:0]  o_data;
  logic [7:0]  i_data;
  logic        mem_ack;
  logic [15:0] hl_o;
  logic [15:0] de_o;
  logic [15:0] bc_o;
  logic [7:0]  f_o;
  logic        busy;
  logic        done;
  logic        again;

  always #5 clock = ~clock;

  z80_blkctl dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .a       (a),
    .f       (f),
    .hl      (hl),
    .de      (de),
    .bc      (bc),
    .brk     (brk),
    .mem_req (mem_req),
    .mem_we  (mem_we),
    .address (address),
    .o_data  (o_data),
    .i_data  (i_data),
    .mem_ack (mem_ack),
    .hl_o    (hl_o),
    .de_o    (de_o),
    .bc_o    (bc_o),
    .f_o     (f_o),
    .busy    (busy),
    .done    (done),
    .again   (again)
  );

  typedef struct {
    logic [15:0] hl;
    logic [15:0] de;
    logic [15:0] bc;
    logic [7:0]  f;
    logic        again;
    int          cyc;
  } res_t;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_t;

  res_t        res_q[$];
  wr_t         wr_q[$];
  logic [7:0]  mem [0:65535];
  int          checks = 0;
  int          errors = 0;
  int          rd_wait = 0;
  int          wr_wait = 0;
  int          wcnt = 0;
  logic [15:0] hold_addr = 16'd0;
  logic        hold_we = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_res(input logic [15:0] h, input logic [15:0] d, input logic [15:0] b,
                          input logic [7:0] fl, input logic ag, input int cy);
    res_t r;
    r.hl = h; r.de = d; r.bc = b; r.f = fl; r.again = ag; r.cyc = cy;
    res_q.push_back(r);
  endtask

  task automatic push_wr(input logic [15:0] ad, input logic [7:0] dt);
    wr_t w;
    w.addr = ad; w.data = dt;
    wr_q.push_back(w);
  endtask

  // Advance to the next falling edge and run the memory model for that cycle.
  task automatic step();
    wr_t w;
    @(negedge clock);
    if (mem_req === 1'b1) begin
      if (wcnt > 0) begin
        chk("hold_addr", {16'd0, address}, {16'd0, hold_addr});
        chk("hold_we", {31'd0, mem_we}, {31'd0, hold_we});
      end
      hold_addr = address;
      hold_we   = mem_we;
      if (wcnt >= (mem_we ? wr_wait : rd_wait)) begin
        mem_ack = 1'b1;
        wcnt    = 0;
        if (mem_we) begin
          chk("wr_expected", {31'd0, (wr_q.size() != 0)}, 32'd1);
          if (wr_q.size() != 0) begin
            w = wr_q.pop_front();
            chk("wr_addr", {16'd0, address}, {16'd0, w.addr});
            chk("wr_data", {24'd0, o_data}, {24'd0, w.data});
            $display("write addr=%h data=%h", address, o_data);
          end
        end else begin
          i_data = mem[address];
        end
      end else begin
        mem_ack = 1'b0;
        wcnt++;
      end
    end else begin
      mem_ack = 1'b0;
      wcnt    = 0;
    end
  endtask

  task automatic run_op(input string name, input logic [2:0] o, input logic [7:0] av,
                        input logic [7:0] fv, input logic [15:0] hv, input logic [15:0] dv,
                        input logic [15:0] bv, input int poke);
    res_t e;
    int   cyc;
    step();
    start = 1'b1; op = o; a = av; f = fv; hl = hv; de = dv; bc = bv;
    cyc = 0;
    do begin
      step();
      cyc++;
      start = 1'b0;
      if (poke != 0 && cyc == poke) begin
        // start while busy must be ignored
        start = 1'b1; op = 3'b011; hl = 16'hDEAD; de = 16'hBEEF; bc = 16'h0000;
      end
      if (cyc == 1) chk({name, "_busy"}, {31'd0, busy}, 32'd1);
    end while (done !== 1'b1 && cyc < 300);
    start = 1'b0;
    chk({name, "_done_seen"}, {31'd0, done}, 32'd1);
    if (res_q.size() != 0) begin
      e = res_q.pop_front();
      chk({name, "_hl"}, {16'd0, hl_o}, {16'd0, e.hl});
      chk({name, "_de"}, {16'd0, de_o}, {16'd0, e.de});
      chk({name, "_bc"}, {16'd0, bc_o}, {16'd0, e.bc});
      chk({name, "_f"}, {24'd0, f_o}, {24'd0, e.f});
      chk({name, "_again"}, {31'd0, again}, {31'd0, e.again});
      chk({name, "_cycles"}, cyc, e.cyc);
      $display("%s: hl=%h de=%h bc=%h f=%h again=%b cycles=%0d",
               name, hl_o, de_o, bc_o, f_o, again, cyc);
      step();
      chk({name, "_done_pulse"}, {31'd0, done}, 32'd0);
      chk({name, "_busy_after"}, {31'd0, busy}, 32'd0);
      chk({name, "_hl_hold"}, {16'd0, hl_o}, {16'd0, e.hl});
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 3'd0; a = 8'd0; f = 8'd0;
    hl = 16'd0; de = 16'd0; bc = 16'd0; brk = 1'b0;
    mem_ack = 1'b0; i_data = 8'd0;

    repeat (3) step();
    reset = 1'b0;
    step();
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_address", {16'd0, address}, 32'd0);
    chk("rst_o_data", {24'd0, o_data}, 32'd0);
    chk("rst_hl", {16'd0, hl_o}, 32'd0);
    chk("rst_de", {16'd0, de_o}, 32'd0);
    chk("rst_bc", {16'd0, bc_o}, 32'd0);
    chk("rst_f", {24'd0, f_o}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_again", {31'd0, again}, 32'd0);

    // LDI: X/Y from A+T = 32 -> Y only
    mem[16'h4000] = 8'h22;
    push_wr(16'h5000, 8'h22);
    push_res(16'h4001, 16'h5001, 16'h0000, 8'h20, 1'b0, 4);
    run_op("ldi", 3'b000, 8'h10, 8'h00, 16'h4000, 16'h5000, 16'h0001, 0);

    // LDIR, BC=3
    mem[16'h4000] = 8'h22; mem[16'h4001] = 8'h33; mem[16'h4002] = 8'h44;
`ifdef Z80_BLKCTL_REPEAT_EN
    push_wr(16'h5000, 8'h22); push_wr(16'h5001, 8'h33); push_wr(16'h5002, 8'h44);
    push_res(16'h4003, 16'h5003, 16'h0000, 8'h00, 1'b0, 10);
`else
    push_wr(16'h5000, 8'h22);
    push_res(16'h4001, 16'h5001, 16'h0002, 8'h24, 1'b1, 4);
`endif
    run_op("ldir", 3'b100, 8'h10, 8'h00, 16'h4000, 16'h5000, 16'h0003, 0);

    // CPIR: match on second byte
    mem[16'h4000] = 8'h11; mem[16'h4001] = 8'h55;
`ifdef Z80_BLKCTL_REPEAT_EN
    push_res(16'h4002, 16'h5000, 16'h0003, 8'h47, 1'b0, 5);
`else
    push_res(16'h4001, 16'h5000, 16'h0004, 8'h07, 1'b1, 3);
`endif
    run_op("cpir", 3'b110, 8'h55, 8'h01, 16'h4000, 16'h5000, 16'h0005, 0);

    // CPD with half borrow: r=1F, H=1, n=1E -> X,Y set
    mem[16'h6000] = 8'h01;
    push_res(16'h5FFF, 16'h1234, 16'h0000, 8'h3A, 1'b0, 3);
    run_op("cpd", 3'b011, 8'h20, 8'h00, 16'h6000, 16'h1234, 16'h0001, 0);

    // LDIR with brk pending: single iteration, again=1 in either build
    brk = 1'b1;
    mem[16'h4000] = 8'h22;
    push_wr(16'h7000, 8'h22);
    push_res(16'h4001, 16'h7001, 16'h0003, 8'h24, 1'b1, 4);
    run_op("ldir_brk", 3'b100, 8'h10, 8'h00, 16'h4000, 16'h7000, 16'h0000 + 16'h0004, 0);
    brk = 1'b0;

    // LDD at the bottom of memory with BC=0: everything wraps to FFFF
    mem[16'h0000] = 8'h0A;
    push_wr(16'h0000, 8'h0A);
    push_res(16'hFFFF, 16'hFFFF, 16'hFFFF, 8'h2C, 1'b0, 4);
    run_op("ldd_wrap", 3'b001, 8'h00, 8'h00, 16'h0000, 16'h0000, 16'h0000, 0);

    // LDI with 3 read wait states and a stray start while busy
    rd_wait = 3;
    mem[16'h4100] = 8'h08;
    push_wr(16'h5100, 8'h08);
    push_res(16'h4101, 16'h5101, 16'h0001, 8'hC5, 1'b0, 7);
    run_op("ldi_wait", 3'b000, 8'h08, 8'hC1, 16'h4100, 16'h5100, 16'h0002, 2);
    rd_wait = 0;

    // Reset while a write is waiting for its ack
    wr_wait = 6;
    mem[16'h4200] = 8'h5A;
    step();
    start = 1'b1; op = 3'b000; a = 8'h00; f = 8'hFF;
    hl = 16'h4200; de = 16'h5200; bc = 16'h0003;
    step();
    start = 1'b0;
    step();
    chk("abort_in_wr", {31'd0, mem_we}, 32'd1);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_mem_req", {31'd0, mem_req}, 32'd0);
    chk("abort_mem_we", {31'd0, mem_we}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_f", {24'd0, f_o}, 32'd0);
    chk("abort_hl", {16'd0, hl_o}, 32'd0);
    chk("abort_address", {16'd0, address}, 32'd0);
    $display("abort: mem_req=%b busy=%b f=%h", mem_req, busy, f_o);
    wr_wait = 0;

    // A following start runs normally
    push_wr(16'h5200, 8'h5A);
    push_res(16'h4201, 16'h5201, 16'h0002, 8'h2C, 1'b0, 4);
    run_op("ldi_after_rst", 3'b000, 8'h00, 8'h00, 16'h4200, 16'h5200, 16'h0003, 0);

    chk("res_q_drained", res_q.size(), 32'd0);
    chk("wr_q_drained", wr_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
